riscv_rvc_align_expand: RTL and testbench

Fetch-side instruction realigner and RV32C expander for the RI5CY core. It buffers 32-bit fetch words and extracts mixed 16/32-bit instructions at halfword granularity, including 32-bit instructions that straddle word boundaries. Compressed instructions are expanded to RV32 equivalents. It sits between the instruction fetch interface and the ID stage, and supersedes the purely combinational compressed decoder with buffering, PC tracking, flush and valid/ready handshakes.

---
 rtl/riscv_rvc_align_expand_if.sv | 28 ++
 rtl/riscv_rvc_align_expand.sv | 226 ++++++++++++++++++++++
 tb/tb_riscv_rvc_align_expand.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_rvc_align_expand_if.sv
// Fetch-side and ID-side handshake bundle for the RVC realigner/expander.
// The fetch unit, flush control and ID stage connect through master; the aligner uses slave.
interface riscv_rvc_align_expand_if;
  logic        fetch_valid_i;
  logic        fetch_ready_o;
  logic [31:0] fetch_rdata_i;
  logic        flush_i;
  logic [31:0] flush_addr_i;
  logic        rvc_en_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_rdata_o;
  logic [31:0] instr_addr_o;
  logic        is_compressed_o;
  logic        illegal_c_o;

  modport master (
    output fetch_valid_i, fetch_rdata_i, flush_i, flush_addr_i, rvc_en_i, instr_ready_i,
    input  fetch_ready_o, instr_valid_o, instr_rdata_o, instr_addr_o, is_compressed_o,
           illegal_c_o
  );

  modport slave (
    input  fetch_valid_i, fetch_rdata_i, flush_i, flush_addr_i, rvc_en_i, instr_ready_i,
    output fetch_ready_o, instr_valid_o, instr_rdata_o, instr_addr_o, is_compressed_o,
           illegal_c_o
  );
endinterface

// File: rtl/riscv_rvc_align_expand.sv
// Fetch-word buffer, halfword realigner and RV32C expander with PC tracking and flush.
// Define RVC_FLOAT_EN to expand c.flw/c.fsw/c.flwsp/c.fswsp; otherwise they are illegal.
module riscv_rvc_align_expand #(
  parameter int unsigned BUF_DEPTH = 2,
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0080
) (
  input logic                     clk,
  input logic                     rst_n,
  riscv_rvc_align_expand_if.slave bus
);
  localparam int unsigned PtrW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] Depth  = CntW'(BUF_DEPTH);
  localparam logic [CntW-1:0] CntOne = CntW'(1);
  localparam logic [CntW-1:0] CntTwo = CntW'(2);

  localparam logic [6:0] OpLoad    = 7'h03;
  localparam logic [6:0] OpLoadFp  = 7'h07;
  localparam logic [6:0] OpImm     = 7'h13;
  localparam logic [6:0] OpStore   = 7'h23;
  localparam logic [6:0] OpStoreFp = 7'h27;
  localparam logic [6:0] OpReg     = 7'h33;
  localparam logic [6:0] OpLui     = 7'h37;
  localparam logic [6:0] OpBranch  = 7'h63;
  localparam logic [6:0] OpJalr    = 7'h67;
  localparam logic [6:0] OpJal     = 7'h6f;

  logic [31:0]     buf_q [BUF_DEPTH];
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, nx_ptr;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            hw_sel_q, hw_sel_d;
  logic [31:0]     pc_q, pc_d;

  logic [31:0] head_w, next_w;
  logic [15:0] h0, h1;
  logic [4:0]  rd, rs2, rd_p, rs1_p;
  logic [2:0]  alu_f3;
  logic        is_c, valid, fetch_rdy, push, take, pop;
  logic [31:0] exp_instr;
  logic        exp_ill;

  assign nx_ptr = rd_ptr_q + PtrW'(1);
  assign head_w = buf_q[rd_ptr_q];
  assign next_w = buf_q[nx_ptr];
  assign h0     = hw_sel_q ? head_w[31:16] : head_w[15:0];
  assign h1     = hw_sel_q ? next_w[15:0]  : head_w[31:16];

  assign is_c  = bus.rvc_en_i & (h0[1:0] != 2'b11);
  // A 32-bit parcel starting in the upper half needs the following word as well.
  assign valid = (cnt_q != '0) & (is_c | ~hw_sel_q | (cnt_q >= CntTwo));

  assign fetch_rdy = (cnt_q < Depth) & ~bus.flush_i;
  assign push      = bus.fetch_valid_i & fetch_rdy;
  assign take      = valid & bus.instr_ready_i & ~bus.flush_i;
  assign pop       = take & (~is_c | hw_sel_q);

  assign bus.fetch_ready_o = fetch_rdy;
  assign bus.instr_valid_o = valid;
  assign bus.instr_addr_o  = pc_q;

  always_comb begin
    if (is_c) begin
      bus.instr_rdata_o   = exp_ill ? {16'h0, h0} : exp_instr;
      bus.is_compressed_o = 1'b1;
      bus.illegal_c_o     = exp_ill;
    end else begin
      bus.instr_rdata_o   = {h1, h0};
      bus.is_compressed_o = 1'b0;
      bus.illegal_c_o     = ~bus.rvc_en_i & (h0[1:0] != 2'b11);
    end
  end

  assign rd     = h0[11:7];
  assign rs2    = h0[6:2];
  assign rd_p   = {2'b01, h0[4:2]};
  assign rs1_p  = {2'b01, h0[9:7]};
  // sub/xor/or/and -> 000/100/110/111
  assign alu_f3 = {h0[6] | h0[5], h0[6], h0[6] & h0[5]};

  always_comb begin
    exp_instr = '0;
    exp_ill   = 1'b0;
    case (h0[1:0])
      2'b00: begin
        case (h0[15:13])
          3'b000: begin
            exp_instr = {2'b0, h0[10:7], h0[12:11], h0[5], h0[6], 2'b00, 5'd2, 3'b000, rd_p,
                         OpImm};
            exp_ill   = (h0[12:5] == 8'h0);
          end
          3'b010: exp_instr = {5'b0, h0[5], h0[12:10], h0[6], 2'b00, rs1_p, 3'b010, rd_p, OpLoad};
          3'b110: exp_instr = {5'b0, h0[5], h0[12], rd_p, rs1_p, 3'b010, h0[11:10], h0[6], 2'b00,
                               OpStore};
`ifdef RVC_FLOAT_EN
          3'b011: exp_instr = {5'b0, h0[5], h0[12:10], h0[6], 2'b00, rs1_p, 3'b010, rd_p,
                               OpLoadFp};
          3'b111: exp_instr = {5'b0, h0[5], h0[12], rd_p, rs1_p, 3'b010, h0[11:10], h0[6], 2'b00,
                               OpStoreFp};
`endif
          default: exp_ill = 1'b1;
        endcase
      end
      2'b01: begin
        case (h0[15:13])
          3'b000: exp_instr = {{6{h0[12]}}, h0[12], rs2, rd, 3'b000, rd, OpImm};
          // c.jal links x1 (funct3 001), c.j links x0 (funct3 101)
          3'b001, 3'b101: exp_instr = {h0[12], h0[8], h0[10:9], h0[6], h0[7], h0[2], h0[11],
                                       h0[5:3], h0[12], {8{h0[12]}}, 4'b0, ~h0[15], OpJal};
          3'b010: begin
            exp_instr = {{6{h0[12]}}, h0[12], rs2, 5'd0, 3'b000, rd, OpImm};
            exp_ill   = (rd == 5'd0);
          end
          3'b011: begin
            if (rd == 5'd2) begin
              exp_instr = {{3{h0[12]}}, h0[4:3], h0[5], h0[2], h0[6], 4'b0, 5'd2, 3'b000, 5'd2,
                           OpImm};
              exp_ill   = ({h0[12], rs2} == 6'h0);
            end else begin
              exp_instr = {{15{h0[12]}}, rs2, rd, OpLui};
              exp_ill   = ({h0[12], rs2} == 6'h0) | (rd == 5'd0);
            end
          end
          3'b100: begin
            case (h0[11:10])
              2'b00, 2'b01: begin
                exp_instr = {1'b0, h0[10], 5'b0, rs2, rs1_p, 3'b101, rs1_p, OpImm};
                exp_ill   = h0[12] | (rs2 == 5'd0);
              end
              2'b10: exp_instr = {{6{h0[12]}}, h0[12], rs2, rs1_p, 3'b111, rs1_p, OpImm};
              default: begin
                exp_instr = {1'b0, h0[6:5] == 2'b00, 5'b0, rd_p, rs1_p, alu_f3, rs1_p, OpReg};
                exp_ill   = h0[12];
              end
            endcase
          end
          default: exp_instr = {h0[12], {3{h0[12]}}, h0[6:5], h0[2], 5'd0, rs1_p, 2'b00, h0[13],
                                h0[11:10], h0[4:3], h0[12], OpBranch};
        endcase
      end
      2'b10: begin
        case (h0[15:13])
          3'b000: begin
            exp_instr = {7'b0, rs2, rd, 3'b001, rd, OpImm};
            exp_ill   = h0[12] | (rs2 == 5'd0) | (rd == 5'd0);
          end
          3'b010: begin
            exp_instr = {4'b0, h0[3:2], h0[12], h0[6:4], 2'b00, 5'd2, 3'b010, rd, OpLoad};
            exp_ill   = (rd == 5'd0);
          end
          3'b100: begin
            if (!h0[12]) begin
              if (rs2 == 5'd0) begin
                exp_instr = {12'b0, rd, 3'b000, 5'd0, OpJalr};
                exp_ill   = (rd == 5'd0);
              end else begin
                exp_instr = {7'b0, rs2, 5'd0, 3'b000, rd, OpReg};
              end
            end else if (rs2 == 5'd0) begin
              exp_instr = (rd == 5'd0) ? 32'h0010_0073 : {12'b0, rd, 3'b000, 5'd1, OpJalr};
            end else begin
              exp_instr = {7'b0, rs2, rd, 3'b000, rd, OpReg};
            end
          end
          3'b110: exp_instr = {4'b0, h0[8:7], h0[12], rs2, 5'd2, 3'b010, h0[11:9], 2'b00, OpStore};
`ifdef RVC_FLOAT_EN
          3'b011: exp_instr = {4'b0, h0[3:2], h0[12], h0[6:4], 2'b00, 5'd2, 3'b010, rd, OpLoadFp};
          3'b111: exp_instr = {4'b0, h0[8:7], h0[12], rs2, 5'd2, 3'b010, h0[11:9], 2'b00,
                               OpStoreFp};
`endif
          default: exp_ill = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    hw_sel_d = hw_sel_q;
    pc_d     = pc_q;
    if (bus.flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
      hw_sel_d = bus.flush_addr_i[1];
      pc_d     = bus.flush_addr_i & 32'hFFFF_FFFE;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        cnt_d    = cnt_d + CntOne;
      end
      if (pop) begin
        rd_ptr_d = nx_ptr;
        cnt_d    = cnt_d - CntOne;
      end
      if (take) begin
        hw_sel_d = is_c ? ~hw_sel_q : hw_sel_q;
        pc_d     = pc_q + (is_c ? 32'd2 : 32'd4);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      hw_sel_q <= 1'b0;
      pc_q     <= BOOT_ADDR;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      hw_sel_q <= hw_sel_d;
      pc_q     <= pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_q[wr_ptr_q] <= bus.fetch_rdata_i;
    end
  end
endmodule

// File: tb/tb_riscv_rvc_align_expand.sv
// Directed bench for riscv_rvc_align_expand: alignment, straddling, flush, backpressure
// and a table of hand-expanded RV32C encodings.
module tb_riscv_rvc_align_expand;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  riscv_rvc_align_expand_if bus ();

  riscv_rvc_align_expand #(
    .BUF_DEPTH(2),
    .BOOT_ADDR(32'h0000_0080)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam int NVec = 18;
  logic [15:0] vec_hw [NVec] = '{
    16'h41C8, 16'hC588, 16'hBFFD, 16'hC501, 16'h852E, 16'h952E, 16'h4532, 16'hC82E, 16'h8082,
    16'h6505, 16'h810D, 16'h8D6D, 16'h717D, 16'h050A, 16'h2011, 16'h9002, 16'h8D0D, 16'h4005
  };
  logic [31:0] vec_ex [NVec] = '{
    32'h0045_A503, 32'h00A5_A423, 32'hFFFF_F06F, 32'h0005_0463, 32'h00B0_0533, 32'h00B5_0533,
    32'h00C1_2503, 32'h00B1_2823, 32'h0000_8067, 32'h0000_1537, 32'h0035_5513, 32'h00B5_7533,
    32'hFF01_0113, 32'h0025_1513, 32'h0040_00EF, 32'h0010_0073, 32'h40B5_0533, 32'h0000_4005
  };
  logic vec_il [NVec] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h, want %08h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.fetch_valid_i = 1'b0;
    bus.fetch_rdata_i = '0;
    bus.flush_i       = 1'b0;
    bus.flush_addr_i  = '0;
    bus.rvc_en_i      = 1'b1;
    bus.instr_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst_valid", 32'(bus.instr_valid_o), 32'd0);
    check_eq("rst_fready", 32'(bus.fetch_ready_o), 32'd1);
    check_eq("rst_pc", bus.instr_addr_o, 32'h80);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [31:0] w);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_rdata_i = w;
    @(negedge clk);
    check_eq("push_ready", 32'(bus.fetch_ready_o), 32'd1);
    @(posedge clk);
    #1 bus.fetch_valid_i = 1'b0;
  endtask

  task automatic expect_instr(input string tag, input logic [31:0] rdata, input logic [31:0] addr,
                              input logic comp, input logic ill, input int max_wait);
    int waited = 0;
    @(negedge clk);
    while (!bus.instr_valid_o && waited < max_wait) begin
      waited++;
      @(negedge clk);
    end
    check_eq({tag, "_valid"}, 32'(bus.instr_valid_o), 32'd1);
    check_eq({tag, "_rdata"}, bus.instr_rdata_o, rdata);
    check_eq({tag, "_addr"}, bus.instr_addr_o, addr);
    check_eq({tag, "_comp"}, 32'(bus.is_compressed_o), 32'(comp));
    check_eq({tag, "_ill"}, 32'(bus.illegal_c_o), 32'(ill));
    bus.instr_ready_i = 1'b1;
    @(posedge clk);
    #1 bus.instr_ready_i = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    @(negedge clk);
    check_eq(tag, 32'(bus.instr_valid_o), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: bench did not complete, n_cmp=%0d", n_cmp);
    $fatal(1, "timeout");
  end

  initial begin
    // Native 32-bit word, visible the cycle after it is written
    do_reset();
    push_word(32'h0000_0013);
    expect_instr("nat32", 32'h0000_0013, 32'h80, 1'b0, 1'b0, 0);
    expect_idle("nat32_empty");

    // Two compressed halfwords in one word
    do_reset();
    push_word(32'h4501_0505);
    expect_instr("c_lo", 32'h0015_0513, 32'h80, 1'b1, 1'b0, 0);
    expect_instr("c_hi", 32'h0000_0513, 32'h82, 1'b1, 1'b0, 0);
    expect_idle("c_empty");

    // 32-bit instruction straddling two words
    do_reset();
    push_word(32'h0013_0505);
    expect_instr("st_c", 32'h0015_0513, 32'h80, 1'b1, 1'b0, 0);
    expect_idle("st_wait");
    push_word(32'h4501_0000);
    expect_instr("st_32", 32'h0000_0013, 32'h82, 1'b0, 1'b0, 0);
    expect_instr("st_tail", 32'h0000_0513, 32'h86, 1'b1, 1'b0, 0);
    expect_idle("st_empty");

    // Flush mid-stream; fetch and consume in the flush cycle are dropped
    do_reset();
    push_word(32'h0505_0505);
    push_word(32'h0000_0013);
    bus.flush_i       = 1'b1;
    bus.flush_addr_i  = 32'h0000_1002;
    bus.fetch_valid_i = 1'b1;
    bus.fetch_rdata_i = 32'hDEAD_BEEF;
    bus.instr_ready_i = 1'b1;
    @(negedge clk);
    check_eq("fl_fready", 32'(bus.fetch_ready_o), 32'd0);
    @(posedge clk);
    #1 idle_inputs();
    @(negedge clk);
    check_eq("fl_valid", 32'(bus.instr_valid_o), 32'd0);
    check_eq("fl_pc", bus.instr_addr_o, 32'h0000_1002);
    @(posedge clk);
    #1;
    push_word(32'h0505_1234);
    expect_instr("fl_first", 32'h0015_0513, 32'h0000_1002, 1'b1, 1'b0, 0);
    expect_idle("fl_empty");

    // Illegal all-zero halfwords, then a 16-bit encoding with C disabled
    do_reset();
    push_word(32'h0000_0000);
    expect_instr("z_lo", 32'h0, 32'h80, 1'b1, 1'b1, 0);
    expect_instr("z_hi", 32'h0, 32'h82, 1'b1, 1'b1, 0);
    bus.rvc_en_i = 1'b0;
    push_word(32'h0000_0505);
    expect_instr("noc", 32'h0000_0505, 32'h84, 1'b0, 1'b1, 0);
    @(negedge clk);
    check_eq("noc_pc", bus.instr_addr_o, 32'h88);
    check_eq("noc_valid", 32'(bus.instr_valid_o), 32'd0);
    @(posedge clk);
    #1 bus.rvc_en_i = 1'b1;

    // Full buffer under backpressure, then simultaneous push and pop
    do_reset();
    push_word(32'h0000_0013);
    push_word(32'h4501_0505);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_rdata_i = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("full_fready", 32'(bus.fetch_ready_o), 32'd0);
      check_eq("full_rdata", bus.instr_rdata_o, 32'h0000_0013);
      check_eq("full_addr", bus.instr_addr_o, 32'h80);
      @(posedge clk);
      #1;
    end
    bus.fetch_valid_i = 1'b0;
    expect_instr("full_a", 32'h0000_0013, 32'h80, 1'b0, 1'b0, 0);
    expect_instr("full_b", 32'h0015_0513, 32'h84, 1'b1, 1'b0, 0);
    bus.fetch_valid_i = 1'b1;
    bus.fetch_rdata_i = 32'h0000_0013;
    bus.instr_ready_i = 1'b1;
    @(negedge clk);
    check_eq("pp_rdata", bus.instr_rdata_o, 32'h0000_0513);
    check_eq("pp_addr", bus.instr_addr_o, 32'h86);
    check_eq("pp_fready", 32'(bus.fetch_ready_o), 32'd1);
    @(posedge clk);
    #1 idle_inputs();
    expect_instr("pp_next", 32'h0000_0013, 32'h88, 1'b0, 1'b0, 0);
    expect_idle("pp_empty");

    // Expansion table, two halfwords per fetch word
    do_reset();
    for (int i = 0; i < NVec / 2; i++) begin
      push_word({vec_hw[2*i+1], vec_hw[2*i]});
      expect_instr($sformatf("vec%0d", 2*i), vec_ex[2*i], 32'h80 + 32'(4*i), 1'b1,
                   vec_il[2*i], 0);
      expect_instr($sformatf("vec%0d", 2*i+1), vec_ex[2*i+1], 32'h82 + 32'(4*i), 1'b1,
                   vec_il[2*i+1], 0);
    end

    // c.flw depends on the float build option
    do_reset();
    push_word(32'h0000_6008);
`ifdef RVC_FLOAT_EN
    expect_instr("flw", 32'h0004_2507, 32'h80, 1'b1, 1'b0, 0);
`else
    expect_instr("flw", 32'h0000_6008, 32'h80, 1'b1, 1'b1, 0);
`endif
    expect_instr("flw_hi", 32'h0, 32'h82, 1'b1, 1'b1, 0);
    expect_idle("flw_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
